bus_arbiter: RTL and testbench

Two-master arbiter that shares the single data bus to the Bridge (Bus_addr/Bus_wdata/Bus_wen/Bus_rdata) between the CPU data port (master 0) and a secondary master such as a program loader or DMA engine (master 1). It sits between the CPU/secondary master and the Bridge. It grants one master at a time using round-robin priority and a bounded burst length. It returns a per-master ack that the CPU uses as its stall condition.

---
 rtl/bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_bus_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter with bounded bursts in front of the Bridge data bus.
// Optional build macro ARB_LOCK_EN adds m0_lock/m1_lock for atomic (non-preemptible) bursts.
module bus_arbiter #(
  parameter int MAX_BURST = 8
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_wen,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_wen,
  input  logic [31:0] m1_wdata,
`ifdef ARB_LOCK_EN
  input  logic        m0_lock,
  input  logic        m1_lock,
`endif
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic [1:0]  gnt,
  output logic [31:0] Bus_addr,
  output logic        Bus_wen,
  output logic [31:0] Bus_wdata,
  input  logic [31:0] Bus_rdata
);

  // Handshake: mx_req is a level held by the master until it sees mx_ack in
  // the same cycle; each cycle with req=1 and ack=1 is exactly one completed access.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [7:0] CNT_MAX = 8'(MAX_BURST - 1);

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic       lock_hold;
  logic       burst_end;

  // gnt is the one-hot view of the FSM state and doubles as its debug view.
  assign gnt = {state_q == OWN1, state_q == OWN0};

  assign m0_ack = (state_q == OWN0) && m0_req && !cpu_rst;
  assign m1_ack = (state_q == OWN1) && m1_req && !cpu_rst;

`ifdef ARB_LOCK_EN
  assign lock_hold = ((state_q == OWN0) && m0_req && m0_lock) ||
                     ((state_q == OWN1) && m1_req && m1_lock);
`else
  assign lock_hold = 1'b0;
`endif

  assign burst_end = (cnt_q == CNT_MAX) && !lock_hold;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (m0_req && m1_req) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (m0_req) begin
          state_d = OWN0;
        end else if (m1_req) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (m0_req) begin
          if (burst_end && m1_req) begin
            state_d = OWN1;
          end else if (!lock_hold && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          state_d = m1_req ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (m1_req) begin
          if (burst_end && m0_req) begin
            state_d = OWN0;
          end else if (!lock_hold && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          state_d = m0_req ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Every new grant starts a fresh burst and becomes the round-robin reference.
    if (state_d != state_q && state_d != IDLE) begin
      cnt_d  = '0;
      last_d = (state_d == OWN1);
    end
  end

  always_comb begin
    Bus_addr  = '0;
    Bus_wdata = '0;
    Bus_wen   = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    if (m0_ack) begin
      Bus_addr  = m0_addr;
      Bus_wdata = m0_wdata;
      Bus_wen   = m0_wen;
      m0_rdata  = Bus_rdata;
    end else if (m1_ack) begin
      Bus_addr  = m1_addr;
      Bus_wdata = m1_wdata;
      Bus_wen   = m1_wen;
      m1_rdata  = Bus_rdata;
    end
  end

`ifndef SYNTHESIS
  a_ack_exclusive : assert property (@(posedge cpu_clk) !(m0_ack && m1_ack));
  a_gnt_onehot0   : assert property (@(posedge cpu_clk) gnt != 2'b11);
  a_no_wen_in_rst : assert property (@(posedge cpu_clk) cpu_rst |-> !Bus_wen);
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (MAX_BURST=8): inputs driven on the falling edge,
// outputs checked 1 time unit later, state advances on the rising edge.
module tb_bus_arbiter;

  logic        clk;
  logic        cpu_rst;
  logic        m0_req, m0_wen, m1_req, m1_wen;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack;
  logic [1:0]  gnt;
  logic [31:0] Bus_addr, Bus_wdata, Bus_rdata;
  logic        Bus_wen;
`ifdef ARB_LOCK_EN
  logic        m0_lock, m1_lock;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  bus_arbiter #(.MAX_BURST(8)) dut (
    .cpu_clk  (clk),
    .cpu_rst  (cpu_rst),
    .m0_req   (m0_req),
    .m0_addr  (m0_addr),
    .m0_wen   (m0_wen),
    .m0_wdata (m0_wdata),
    .m1_req   (m1_req),
    .m1_addr  (m1_addr),
    .m1_wen   (m1_wen),
    .m1_wdata (m1_wdata),
`ifdef ARB_LOCK_EN
    .m0_lock  (m0_lock),
    .m1_lock  (m1_lock),
`endif
    .m0_rdata (m0_rdata),
    .m0_ack   (m0_ack),
    .m1_rdata (m1_rdata),
    .m1_ack   (m1_ack),
    .gnt      (gnt),
    .Bus_addr (Bus_addr),
    .Bus_wen  (Bus_wen),
    .Bus_wdata(Bus_wdata),
    .Bus_rdata(Bus_rdata)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drops both requests from an owned state; the next edge returns to IDLE.
  task automatic go_idle(input string tag);
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0; m0_wen = 1'b1; m1_wen = 1'b1;
    #1;
    n_checks++;
    if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
      n_fail++; $display("FAIL %s_idle_ack: acks=%b%b expected 00", tag, m1_ack, m0_ack);
    end
    n_checks++;
    if (Bus_wen !== 1'b0 || Bus_addr !== 32'h0) begin
      n_fail++; $display("FAIL %s_idle_bus: wen=%b addr=%h expected 0/0", tag, Bus_wen, Bus_addr);
    end
    m0_wen = 1'b0; m1_wen = 1'b0;
  endtask

  task automatic test_reset();
    cpu_rst = 1'b1; m0_req = 1'b1; m1_req = 1'b1; m0_wen = 1'b1; m1_wen = 1'b1;
    m0_addr = 32'h10; m1_addr = 32'h20; m0_wdata = 32'h1; m1_wdata = 32'h2;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (gnt !== 2'b00 || m0_ack !== 1'b0 || m1_ack !== 1'b0 || Bus_wen !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: gnt=%b acks=%b%b wen=%b expected 00/00/0", i, gnt, m1_ack, m0_ack, Bus_wen);
      end
    end
    @(negedge clk); cpu_rst = 1'b0; #1;
    n_checks++;
    if (gnt !== 2'b00 || m0_ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_idle: gnt=%b m0_ack=%b expected 00/0", gnt, m0_ack);
    end
    @(negedge clk); #1;
    n_checks++;
    if (gnt !== 2'b01) begin
      n_fail++; $display("FAIL reset_first_gnt: gnt=%b expected 01", gnt);
    end
    n_checks++;
    if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_first_ack: acks=%b%b expected 01", m1_ack, m0_ack);
    end
    go_idle("reset");
  endtask

  task automatic test_single_stream();
    logic [31:0] a;
    @(negedge clk);
    m1_req = 1'b1; m1_wen = 1'b1; m1_addr = 32'h8000_0000; m1_wdata = 32'hA000_0000;
    #1;
    n_checks++;
    if (m1_ack !== 1'b0 || gnt !== 2'b00) begin
      n_fail++; $display("FAIL stream_latency: m1_ack=%b gnt=%b expected 0/00", m1_ack, gnt);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      a = 32'h8000_0000 + 32'(4 * k);
      m1_addr = a; m1_wdata = 32'hA000_0000 + 32'(k);
      #1;
      n_checks++;
      if (m1_ack !== 1'b1 || m0_ack !== 1'b0 || gnt !== 2'b10) begin
        n_fail++; $display("FAIL stream_ack[%0d]: acks=%b%b gnt=%b expected 10/10", k, m1_ack, m0_ack, gnt);
      end
      n_checks++;
      if (Bus_addr !== a || Bus_wdata !== 32'hA000_0000 + 32'(k) || Bus_wen !== 1'b1) begin
        n_fail++; $display("FAIL stream_bus[%0d]: addr=%h wdata=%h wen=%b expected %h", k, Bus_addr, Bus_wdata, Bus_wen, a);
      end
    end
    go_idle("stream");
  endtask

  task automatic test_contention();
    logic [1:0] e;
    for (int i = 0; i < 24; i++) exp_q.push_back((((i / 8) % 2) == 1) ? 2'b10 : 2'b01);
    @(negedge clk);
    m0_req = 1'b1; m1_req = 1'b0; m0_wen = 1'b0; m1_wen = 1'b0;
    #1;
    n_checks++;
    if (m0_ack !== 1'b0) begin
      n_fail++; $display("FAIL contend_latency: m0_ack=%b expected 0", m0_ack);
    end
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      m1_req = 1'b1; m0_addr = 32'h100 + 32'(i); m1_addr = 32'h200 + 32'(i);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (gnt !== e || {m1_ack, m0_ack} !== e) begin
        n_fail++; $display("FAIL contend_owner[%0d]: gnt=%b acks=%b%b expected %b", i, gnt, m1_ack, m0_ack, e);
      end
      n_checks++;
      if (Bus_addr !== (e[0] ? m0_addr : m1_addr)) begin
        n_fail++; $display("FAIL contend_addr[%0d]: addr=%h expected %h", i, Bus_addr, e[0] ? m0_addr : m1_addr);
      end
    end
    go_idle("contend");
  endtask

  task automatic test_saturated_preempt();
    @(negedge clk);
    m0_req = 1'b1; m1_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (m0_ack !== 1'b1) begin
        n_fail++; $display("FAIL sat_stream[%0d]: m0_ack=%b expected 1", i, m0_ack);
      end
    end
    @(negedge clk); m1_req = 1'b1; #1;
    n_checks++;
    if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
      n_fail++; $display("FAIL sat_last_m0: acks=%b%b expected 01", m1_ack, m0_ack);
    end
    @(negedge clk); #1;
    n_checks++;
    if (m1_ack !== 1'b1 || m0_ack !== 1'b0 || gnt !== 2'b10) begin
      n_fail++; $display("FAIL sat_handover: acks=%b%b gnt=%b expected 10/10", m1_ack, m0_ack, gnt);
    end
    go_idle("sat");
  endtask

  task automatic test_release_handover();
    @(negedge clk);
    m0_req = 1'b1; m1_req = 1'b0;
    @(negedge clk); m1_req = 1'b1; #1;
    n_checks++;
    if (m0_ack !== 1'b1) begin
      n_fail++; $display("FAIL rel_owner_ack: m0_ack=%b expected 1", m0_ack);
    end
    @(negedge clk); m0_req = 1'b0; m0_wen = 1'b1; m1_wen = 1'b1; #1;
    n_checks++;
    if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || Bus_wen !== 1'b0 || gnt !== 2'b01) begin
      n_fail++; $display("FAIL rel_drop_cycle: acks=%b%b wen=%b gnt=%b expected 00/0/01", m1_ack, m0_ack, Bus_wen, gnt);
    end
    @(negedge clk); #1;
    n_checks++;
    if (m1_ack !== 1'b1 || gnt !== 2'b10 || Bus_wen !== 1'b1) begin
      n_fail++; $display("FAIL rel_new_owner: m1_ack=%b gnt=%b wen=%b expected 1/10/1", m1_ack, gnt, Bus_wen);
    end
    go_idle("rel");
  endtask

  task automatic test_read_path();
    @(negedge clk);
    Bus_rdata = 32'hDEAD_BEEF; m1_req = 1'b1; m1_wen = 1'b0; m0_req = 1'b0;
    #1;
    n_checks++;
    if (m1_rdata !== 32'h0 || m0_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rd_idle: m1_rdata=%h m0_rdata=%h expected 0/0", m1_rdata, m0_rdata);
    end
    @(negedge clk); m0_req = 1'b1; #1;
    n_checks++;
    if (m1_ack !== 1'b1 || m1_rdata !== 32'hDEAD_BEEF || m0_rdata !== 32'h0 || Bus_wen !== 1'b0) begin
      n_fail++; $display("FAIL rd_owner: ack=%b m1_rdata=%h m0_rdata=%h wen=%b expected 1/deadbeef/0/0", m1_ack, m1_rdata, m0_rdata, Bus_wen);
    end
    Bus_rdata = 32'h1234_5678; #1;
    n_checks++;
    if (m1_rdata !== 32'h1234_5678 || m0_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rd_comb: m1_rdata=%h m0_rdata=%h expected 12345678/0", m1_rdata, m0_rdata);
    end
    go_idle("rd");
  endtask

  task automatic test_round_robin_tie();
    @(negedge clk);
    m0_req = 1'b1; m1_req = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (m0_ack !== 1'b1) begin
      n_fail++; $display("FAIL tie_setup: m0_ack=%b expected 1", m0_ack);
    end
    @(negedge clk); m0_req = 1'b0;
    @(negedge clk); m0_req = 1'b1; m1_req = 1'b1; #1;
    n_checks++;
    if (gnt !== 2'b00 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
      n_fail++; $display("FAIL tie_idle: gnt=%b acks=%b%b expected 00/00", gnt, m1_ack, m0_ack);
    end
    @(negedge clk); #1;
    n_checks++;
    if (gnt !== 2'b10 || m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
      n_fail++; $display("FAIL tie_pick_m1: gnt=%b acks=%b%b expected 10/10", gnt, m1_ack, m0_ack);
    end
    go_idle("tie");
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    m0_req = 1'b1; m0_wen = 1'b1; m1_req = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (m0_ack !== 1'b1 || Bus_wen !== 1'b1) begin
      n_fail++; $display("FAIL mrst_setup: m0_ack=%b wen=%b expected 1/1", m0_ack, Bus_wen);
    end
    @(negedge clk); cpu_rst = 1'b1; #1;
    n_checks++;
    if (m0_ack !== 1'b0 || Bus_wen !== 1'b0 || gnt !== 2'b01) begin
      n_fail++; $display("FAIL mrst_suppress: ack=%b wen=%b gnt=%b expected 0/0/01", m0_ack, Bus_wen, gnt);
    end
    @(negedge clk); cpu_rst = 1'b0; m0_req = 1'b0; m0_wen = 1'b0; #1;
    n_checks++;
    if (gnt !== 2'b00) begin
      n_fail++; $display("FAIL mrst_idle: gnt=%b expected 00", gnt);
    end
    @(negedge clk); m0_req = 1'b1; m1_req = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (gnt !== 2'b01 || m0_ack !== 1'b1) begin
      n_fail++; $display("FAIL mrst_last_reset: gnt=%b m0_ack=%b expected 01/1", gnt, m0_ack);
    end
    go_idle("mrst");
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    @(negedge clk);
    m0_req = 1'b1; m0_lock = 1'b1; m1_req = 1'b0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      m1_req = 1'b1; m0_lock = (i < 12);
      #1;
      n_checks++;
      if (m0_ack !== (i < 20) || m1_ack !== (i >= 20)) begin
        n_fail++; $display("FAIL lock_seq[%0d]: acks=%b%b", i, m1_ack, m0_ack);
      end
    end
    m0_lock = 1'b0;
    go_idle("lock");
  endtask
`endif

  initial begin
    cpu_rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0; m0_wen = 1'b0; m1_wen = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; Bus_rdata = 32'h5555_AAAA;
`ifdef ARB_LOCK_EN
    m0_lock = 1'b0; m1_lock = 1'b0;
`endif
    test_reset();
    test_single_stream();
    test_contention();
    test_saturated_preempt();
    test_release_handover();
    test_read_path();
    test_round_robin_tie();
    test_reset_mid_burst();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
